// File: rtl/conv_pkg.sv
// Shared types, defaults and puncture tables for the streaming convolutional encoder.
package conv_pkg;

  localparam int unsigned K_MAX_DEF = 7;
  localparam int unsigned N_MAX_DEF = 3;
  localparam int unsigned PHASE_W   = 2;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'd0,
    RATE_1_3 = 2'd1,
    RATE_2_3 = 2'd2,
    RATE_3_4 = 2'd3
  } rate_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_e;

  // Transmit masks, bit0 = polynomial 0
  localparam logic [2:0] MASK_1_2     = 3'b011;
  localparam logic [2:0] MASK_1_3     = 3'b111;
  localparam logic [2:0] MASK_2_3 [2] = '{3'b011, 3'b001};
  localparam logic [2:0] MASK_3_4 [3] = '{3'b011, 3'b001, 3'b010};

  // Number of symbols in one puncturing period
  function automatic logic [PHASE_W-1:0] punct_period(input rate_mode_e rate);
    case (rate)
      RATE_2_3: punct_period = PHASE_W'(2);
      RATE_3_4: punct_period = PHASE_W'(3);
      default:  punct_period = PHASE_W'(1);
    endcase
  endfunction

  // Mask for a given rate and puncture phase
  function automatic logic [2:0] punct_mask(input rate_mode_e rate, input logic [PHASE_W-1:0] phase);
    punct_mask = MASK_1_2;
    case (rate)
      RATE_1_2: punct_mask = MASK_1_2;
      RATE_1_3: punct_mask = MASK_1_3;
      RATE_2_3: punct_mask = phase[0] ? MASK_2_3[1] : MASK_2_3[0];
      RATE_3_4: begin
        case (phase)
          PHASE_W'(1): punct_mask = MASK_3_4[1];
          PHASE_W'(2): punct_mask = MASK_3_4[2];
          default:     punct_mask = MASK_3_4[0];
        endcase
      end
      default: punct_mask = MASK_1_2;
    endcase
  endfunction

endpackage

// File: rtl/conv_encoder_stream_if.sv
// Input-bit and coded-symbol valid/ready streams of the convolutional encoder.
interface conv_encoder_stream_if #(
  parameter int unsigned N = conv_pkg::N_MAX_DEF
);
  logic         s_valid;
  logic         s_ready;
  logic         s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] m_data;
  logic [N-1:0] m_mask;
  logic         m_last;

  // Encoder side: sinks information bits, sources coded symbols
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_mask, m_last
  );

  // Environment side: sources information bits, sinks coded symbols
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_mask, m_last
  );
endinterface

// File: rtl/conv_encoder_stream_puncture_ctrl.sv
// Puncture phase counter with mask lookup; clear forces phase 0 for the current symbol.
module puncture_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned N = N_MAX_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       advance_i,
  input  rate_mode_e rate_i,
  output logic [N-1:0] mask_c_o
);
  localparam int unsigned EXT_W = (N > 3) ? N : 3;

  logic [PHASE_W-1:0] phase_q, phase_d, phase_c, phase_inc_c;
  logic [EXT_W-1:0]   mask_ext_c;

  // Current phase, wrapped next phase and width-adjusted mask
  always_comb begin
    phase_c     = clear_i ? '0 : phase_q;
    phase_inc_c = phase_c + PHASE_W'(1);
    phase_d     = phase_q;
    if (advance_i) begin
      phase_d = (phase_inc_c >= punct_period(rate_i)) ? '0 : phase_inc_c;
    end else if (clear_i) begin
      phase_d = '0;
    end
    mask_ext_c = EXT_W'(punct_mask(rate_i, phase_c));
    mask_c_o   = mask_ext_c[N-1:0];
  end

  // Phase register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/conv_encoder_stream.sv
// Streaming convolutional encoder with per-frame constraint length, rate and polynomials.
// Optional CONV_ZERO_TAIL_EN: append k-1 zero-termination tail symbols per frame.
module conv_encoder_stream
  import conv_pkg::*;
#(
  parameter int unsigned K_MAX = K_MAX_DEF,
  parameter int unsigned N_MAX = N_MAX_DEF
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic [$clog2(K_MAX+1)-1:0]   i_k,
  input  logic [1:0]                   i_rate_mode,
  input  logic [K_MAX*N_MAX-1:0]       i_gen_poly_flat,
  conv_encoder_stream_if.slave         bus
);
  localparam int unsigned KW   = $clog2(K_MAX + 1);
  localparam int unsigned SR_W = K_MAX - 1;

  enc_state_e             state_q;
  logic [KW-1:0]          k_q;
  rate_mode_e             rate_q;
  logic [K_MAX*N_MAX-1:0] poly_q;
  logic [SR_W-1:0]        sr_q, sr_d;
  logic                   m_valid_q, m_last_q;
  logic [N_MAX-1:0]       m_data_q, m_mask_q;
`ifdef CONV_ZERO_TAIL_EN
  logic [KW-1:0]          tail_q;
`endif

  logic                   out_free_c, s_ready_c, accept_c, first_c;
  logic                   tail_fire_c, emit_c, last_c, in_bit_c;
  int unsigned            k_int_c;
  logic [KW-1:0]          k_sat_c, k_eff_c;
  rate_mode_e             rate_eff_c;
  logic [K_MAX*N_MAX-1:0] poly_eff_c;
  logic [SR_W-1:0]        hist_c;
  logic [K_MAX-1:0]       kmask_c, win_c;
  logic [N_MAX-1:0]       code_c, punct_mask_c;

  // Handshake, effective frame configuration and encoder window
  always_comb begin
    out_free_c = !m_valid_q || bus.m_ready;
    s_ready_c  = !rst && ((state_q == IDLE) || (state_q == DATA)) && out_free_c;
    accept_c   = bus.s_valid && s_ready_c;
    first_c    = (state_q == IDLE);

    k_int_c = 32'(i_k);
    if (k_int_c < 32'd2) begin
      k_sat_c = KW'(2);
    end else if (k_int_c > K_MAX) begin
      k_sat_c = KW'(K_MAX);
    end else begin
      k_sat_c = i_k;
    end

    k_eff_c    = first_c ? k_sat_c : k_q;
    rate_eff_c = first_c ? rate_mode_e'(i_rate_mode) : rate_q;
    poly_eff_c = first_c ? i_gen_poly_flat : poly_q;

`ifdef CONV_ZERO_TAIL_EN
    tail_fire_c = (state_q == TAIL) && out_free_c && (tail_q != '0);
    last_c      = tail_fire_c && (tail_q == KW'(1));
`else
    tail_fire_c = 1'b0;
    last_c      = accept_c && bus.s_last;
`endif
    emit_c   = accept_c || tail_fire_c;
    in_bit_c = accept_c && bus.s_data;

    // A new frame starts from the all-zero encoder state
    hist_c = first_c ? '0 : sr_q;
    for (int unsigned i = 0; i < K_MAX; i++) begin
      kmask_c[i] = (i < 32'(k_eff_c));
    end
    win_c = {hist_c, in_bit_c} & kmask_c;
    sr_d  = win_c[SR_W-1:0];

    for (int unsigned j = 0; j < N_MAX; j++) begin
      code_c[j] = ^(poly_eff_c[j*K_MAX +: K_MAX] & win_c);
    end
  end

  puncture_ctrl #(
    .N (N_MAX)
  ) u_punct (
    .clk_i     (sys_clk),
    .rst_i     (rst),
    .clear_i   (accept_c && first_c),
    .advance_i (emit_c),
    .rate_i    (rate_eff_c),
    .mask_c_o  (punct_mask_c)
  );

  // Frame FSM, shift register and registered output symbol
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= KW'(2);
      rate_q    <= RATE_1_2;
      poly_q    <= '0;
      sr_q      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_mask_q  <= '0;
      m_last_q  <= 1'b0;
`ifdef CONV_ZERO_TAIL_EN
      tail_q    <= '0;
`endif
    end else begin
      if (emit_c) begin
        m_valid_q <= 1'b1;
        m_data_q  <= code_c & punct_mask_c;
        m_mask_q  <= punct_mask_c;
        m_last_q  <= last_c;
        sr_q      <= sr_d;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept_c) begin
            k_q    <= k_sat_c;
            rate_q <= rate_eff_c;
            poly_q <= i_gen_poly_flat;
            if (bus.s_last) begin
`ifdef CONV_ZERO_TAIL_EN
              state_q <= TAIL;
              tail_q  <= k_sat_c - KW'(1);
`else
              state_q <= IDLE;
`endif
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_c && bus.s_last) begin
`ifdef CONV_ZERO_TAIL_EN
            state_q <= TAIL;
            tail_q  <= k_q - KW'(1);
`else
            state_q <= IDLE;
`endif
          end
        end
`ifdef CONV_ZERO_TAIL_EN
        TAIL: begin
          if (out_free_c) begin
            if (tail_q != '0) begin
              tail_q <= tail_q - KW'(1);
            end else begin
              state_q <= IDLE;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_mask  = m_mask_q;
  assign bus.m_last  = m_last_q;

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Self-checking bench for conv_encoder_stream (K_MAX=7, N_MAX=3).
module tb_conv_encoder_stream;

`ifdef CONV_ZERO_TAIL_EN
  localparam bit TAIL_ON = 1'b1;
`else
  localparam bit TAIL_ON = 1'b0;
`endif

  typedef struct {
    logic [2:0] d;
    logic [2:0] m;
    logic       l;
  } sym_t;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [2:0]  i_k;
  logic [1:0]  i_rate_mode;
  logic [20:0] i_gen_poly_flat;

  conv_encoder_stream_if bus ();

  conv_encoder_stream dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .i_k             (i_k),
    .i_rate_mode     (i_rate_mode),
    .i_gen_poly_flat (i_gen_poly_flat),
    .bus             (bus)
  );

  always #5 sys_clk = ~sys_clk;

  sym_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   sym_cnt    = 0;
  int   stall_at   = -1;
  int   stall_len  = 0;
  int   stall_done = 0;

  // Polynomial sets {poly2, poly1, poly0}
  localparam logic [20:0] P3 = {7'b0000000, 7'b0000101, 7'b0000111};
  localparam logic [20:0] P7 = {7'b1100101, 7'b1011011, 7'b1111001};
  localparam logic [20:0] P5 = {7'b0011111, 7'b0011101, 7'b0010011};
  localparam logic [20:0] P4 = {7'b0000000, 7'b0001011, 7'b0001101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmit mask for symbol n of a frame
  function automatic logic [2:0] model_mask(input int rate, input int n);
    case (rate)
      0: return 3'b011;
      1: return 3'b111;
      2: return (n % 2 == 0) ? 3'b011 : 3'b001;
      default: begin
        case (n % 3)
          0: return 3'b011;
          1: return 3'b001;
          default: return 3'b010;
        endcase
      end
    endcase
  endfunction

  function automatic int model_len(input int n, input int k, input bit term);
    if (term && TAIL_ON) return n + k - 1;
    return n;
  endfunction

  // Symbol s as a direct convolution of the bit sequence (tail bits are zeros)
  function automatic sym_t model_sym(input logic [15:0] bits, input int n, input int k,
                                     input int rate, input logic [20:0] polys,
                                     input bit term, input int s);
    sym_t r;
    logic [2:0] code;
    code = 3'b000;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < k; i++) begin
        if ((s - i) >= 0 && (s - i) < n) begin
          if (polys[j*7 + i] && bits[s - i]) code[j] = ~code[j];
        end
      end
    end
    r.m = model_mask(rate, s);
    r.d = code & r.m;
    r.l = term && (s == model_len(n, k, term) - 1);
    return r;
  endfunction

  // Downstream ready: optional stall once sym_cnt reaches stall_at
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sym_cnt == stall_at && stall_done < stall_len) begin
        bus.m_ready = 1'b0;
        stall_done++;
      end else begin
        bus.m_ready = 1'b1;
      end
    end
  end

  // Compare every transferred symbol against the model; check hold under backpressure
  initial begin
    bit   held;
    sym_t prev;
    sym_t e;
    held = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        held = 1'b0;
      end else if (bus.m_valid) begin
        if (held) begin
          chk("hold_data", 32'(bus.m_data), 32'(prev.d));
          chk("hold_mask", 32'(bus.m_mask), 32'(prev.m));
          chk("hold_last", 32'(bus.m_last), 32'(prev.l));
        end
        if (bus.m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_symbol: got data %0h mask %0h with none expected at %0t",
                     bus.m_data, bus.m_mask, $time);
          end else begin
            e = exp_q.pop_front();
            chk("sym_data", 32'(bus.m_data), 32'(e.d));
            chk("sym_mask", 32'(bus.m_mask), 32'(e.m));
            chk("sym_last", 32'(bus.m_last), 32'(e.l));
          end
          sym_cnt++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          prev.d = bus.m_data;
          prev.m = bus.m_mask;
          prev.l = bus.m_last;
          chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
        end
      end else begin
        if (held) chk("hold_valid", 32'(bus.m_valid), 32'd1);
        held = 1'b0;
      end
    end
  end

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge sys_clk);
      if (bus.s_ready) begin
        @(posedge sys_clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: s_ready never rose at %0t", $time);
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge sys_clk);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Send one terminated frame; optionally disturb the config after the first bit
  task automatic run_frame(input string tag, input logic [15:0] bits, input int n, input int k,
                           input int rate, input logic [20:0] polys, input bit cfg_change);
    bit ok;
    int start_cnt;
    @(posedge sys_clk);
    #1;
    i_k             = 3'(k);
    i_rate_mode     = 2'(rate);
    i_gen_poly_flat = polys;
    start_cnt       = sym_cnt;
    for (int s = 0; s < model_len(n, k, 1'b1); s++) exp_q.push_back(model_sym(bits, n, k, rate, polys, 1'b1, s));
    for (int b = 0; b < n; b++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = bits[b];
      bus.s_last  = (b == n - 1);
      wait_accept(ok);
      if (!ok) break;
      if (cfg_change && b == 0) begin
        i_k             = 3'd5;
        i_rate_mode     = 2'd1;
        i_gen_poly_flat = P5;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    wait_drain(tag);
    chk({tag, "_count"}, 32'(sym_cnt - start_cnt), 32'(model_len(n, k, 1'b1)));
  endtask

  logic [2:0] lit12_d [6] = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b011};
  logic [2:0] lit34_d [6] = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b000, 3'b010};
  logic [2:0] lit34_m [6] = '{3'b011, 3'b001, 3'b010, 3'b011, 3'b001, 3'b010};

  initial begin
    bit   ok;
    int   len;
    sym_t r;

    rst             = 1'b1;
    bus.s_valid     = 1'b0;
    bus.s_data      = 1'b0;
    bus.s_last      = 1'b0;
    i_k             = 3'd3;
    i_rate_mode     = 2'd0;
    i_gen_poly_flat = P3;

    // Pin the model against hand-computed sequences
    len = model_len(4, 3, 1'b1);
`ifdef CONV_ZERO_TAIL_EN
    chk("pin_len", 32'(len), 32'd6);
`else
    chk("pin_len", 32'(len), 32'd4);
`endif
    for (int s = 0; s < len; s++) begin
      r = model_sym(16'b1101, 4, 3, 0, P3, 1'b1, s);
      chk("pin_r12_data", 32'(r.d), 32'(lit12_d[s]));
      chk("pin_r12_last", 32'(r.l), 32'(s == len - 1));
      r = model_sym(16'b1101, 4, 3, 3, P3, 1'b1, s);
      chk("pin_r34_data", 32'(r.d), 32'(lit34_d[s]));
      chk("pin_r34_mask", 32'(r.m), 32'(lit34_m[s]));
    end

    // Reset state
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data",  32'(bus.m_data),  32'd0);
    chk("rst_m_mask",  32'(bus.m_mask),  32'd0);
    chk("rst_m_last",  32'(bus.m_last),  32'd0);
    @(posedge sys_clk);
    #1;
    rst = 1'b0;

    run_frame("rate12", 16'b1101, 4, 3, 0, P3, 1'b0);
    run_frame("rate34", 16'b1101, 4, 3, 3, P3, 1'b0);

    // Backpressure on the second symbol
    stall_at  = sym_cnt + 1;
    stall_len = 3;
    run_frame("bp", 16'b1101, 4, 3, 0, P3, 1'b0);
    chk("bp_stall_cycles", 32'(stall_done), 32'd3);

    run_frame("single", 16'b1, 1, 7, 1, P7, 1'b0);
    run_frame("rate23", 16'b11001, 5, 4, 2, P4, 1'b0);

    // Reset mid-frame with a symbol still pending
    @(posedge sys_clk);
    #1;
    i_k             = 3'd3;
    i_rate_mode     = 2'd3;
    i_gen_poly_flat = P3;
    exp_q.push_back(model_sym(16'b01, 2, 3, 3, P3, 1'b0, 0));
    bus.s_valid = 1'b1;
    bus.s_data  = 1'b1;
    bus.s_last  = 1'b0;
    wait_accept(ok);
    bus.s_data = 1'b0;
    wait_accept(ok);
    bus.s_valid = 1'b0;
    rst         = 1'b1;
    @(negedge sys_clk);
    chk("abort_s_ready", 32'(bus.s_ready), 32'd0);
    @(posedge sys_clk);
    #1;
    chk("abort_m_valid", 32'(bus.m_valid), 32'd0);
    chk("abort_m_data",  32'(bus.m_data),  32'd0);
    chk("abort_m_mask",  32'(bus.m_mask),  32'd0);
    chk("abort_m_last",  32'(bus.m_last),  32'd0);
    chk("abort_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge sys_clk);
    chk("abort_idle_ready", 32'(bus.s_ready), 32'd1);
    run_frame("after_rst", 16'b1101, 4, 3, 3, P3, 1'b0);

    // Config change mid-frame, then a frame with the new config
    run_frame("cfg_old", 16'b1101, 4, 3, 0, P3, 1'b1);
    run_frame("cfg_new", 16'b01101011, 8, 5, 1, P5, 1'b0);

    repeat (3) @(posedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
